// File: rtl/stopwatch_time_core.sv
// Stopwatch MM:SS time core: four BCD digits with run/pause/adjust and a 7-segment encode.
// Latency: count updates on the edge that samples a qualifying tick; segments follow one edge later.
// Backpressure: none; ticks and pause pulses are single-cycle enables that are never stalled.
//
// Ports:
//   clk_fast, rst            - block clock, asynchronous active-high reset
//   tick_run, tick_adj       - 1 Hz run enable, 2 Hz adjust enable (one cycle wide)
//   adj, sel                 - adjust mode level; field select (1 = seconds, 0 = minutes)
//   pause_pulse              - toggles the pause state
//   c_0..c_3                 - active-low segments {g,f,e,d,c,b,a}: s_one, s_ten, m_one, m_ten
//   paused, wrap             - pause state; one-cycle pulse on the 59:59 -> 00:00 run rollover
//
// Build option: define STOPWATCH_LEADING_BLANK_EN to blank c_3 whenever the minutes-tens digit is 0.
module stopwatch_time_core (
  input  logic       clk_fast,
  input  logic       rst,
  input  logic       tick_run,
  input  logic       tick_adj,
  input  logic       adj,
  input  logic       sel,
  input  logic       pause_pulse,
  output logic [6:0] c_0,
  output logic [6:0] c_1,
  output logic [6:0] c_2,
  output logic [6:0] c_3,
  output logic       paused,
  output logic       wrap
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

`ifdef STOPWATCH_LEADING_BLANK_EN
  localparam logic [6:0] C3_RST = SEG_BLANK;
`else
  localparam logic [6:0] C3_RST = SEG_ZERO;
`endif

  logic [3:0] s_one_q, s_one_d;
  logic [2:0] s_ten_q, s_ten_d;
  logic [3:0] m_one_q, m_one_d;
  logic [2:0] m_ten_q, m_ten_d;
  logic       paused_q, paused_d;
  logic       wrap_q, wrap_d;
  logic [6:0] c_0_q, c_0_d;
  logic [6:0] c_1_q, c_1_d;
  logic [6:0] c_2_q, c_2_d;
  logic [6:0] c_3_q, c_3_d;

  logic run_en;
  logic adj_en;

  // Ticks are qualified by the pre-toggle pause state, so a tick coincident
  // with pause_pulse still acts under the old state.
  assign run_en = ~adj & ~paused_q & tick_run;
  assign adj_en = adj & tick_adj;

  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  always_comb begin
    s_one_d  = s_one_q;
    s_ten_d  = s_ten_q;
    m_one_d  = m_one_q;
    m_ten_d  = m_ten_q;
    paused_d = paused_q ^ pause_pulse;
    wrap_d   = 1'b0;

    if (run_en) begin
      // Ripple carry through the four digits; only the full rollover pulses wrap.
      if (s_one_q == 4'd9) begin
        s_one_d = 4'd0;
        if (s_ten_q == 3'd5) begin
          s_ten_d = 3'd0;
          if (m_one_q == 4'd9) begin
            m_one_d = 4'd0;
            if (m_ten_q == 3'd5) begin
              m_ten_d = 3'd0;
              wrap_d  = 1'b1;
            end else begin
              m_ten_d = m_ten_q + 3'd1;
            end
          end else begin
            m_one_d = m_one_q + 4'd1;
          end
        end else begin
          s_ten_d = s_ten_q + 3'd1;
        end
      end else begin
        s_one_d = s_one_q + 4'd1;
      end
    end else if (adj_en) begin
      // Adjust wraps the selected 00-59 pair in place, never carrying across fields.
      if (sel) begin
        if (s_one_q == 4'd9) begin
          s_one_d = 4'd0;
          s_ten_d = (s_ten_q == 3'd5) ? 3'd0 : s_ten_q + 3'd1;
        end else begin
          s_one_d = s_one_q + 4'd1;
        end
      end else begin
        if (m_one_q == 4'd9) begin
          m_one_d = 4'd0;
          m_ten_d = (m_ten_q == 3'd5) ? 3'd0 : m_ten_q + 3'd1;
        end else begin
          m_one_d = m_one_q + 4'd1;
        end
      end
    end

    // Segments are encoded from the registered count, landing one edge after it.
    c_0_d = seg_enc(s_one_q);
    c_1_d = seg_enc({1'b0, s_ten_q});
    c_2_d = seg_enc(m_one_q);
`ifdef STOPWATCH_LEADING_BLANK_EN
    c_3_d = (m_ten_q == 3'd0) ? SEG_BLANK : seg_enc({1'b0, m_ten_q});
`else
    c_3_d = seg_enc({1'b0, m_ten_q});
`endif
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      s_one_q  <= 4'd0;
      s_ten_q  <= 3'd0;
      m_one_q  <= 4'd0;
      m_ten_q  <= 3'd0;
      paused_q <= 1'b0;
      wrap_q   <= 1'b0;
      c_0_q    <= SEG_ZERO;
      c_1_q    <= SEG_ZERO;
      c_2_q    <= SEG_ZERO;
      c_3_q    <= C3_RST;
    end else begin
      s_one_q  <= s_one_d;
      s_ten_q  <= s_ten_d;
      m_one_q  <= m_one_d;
      m_ten_q  <= m_ten_d;
      paused_q <= paused_d;
      wrap_q   <= wrap_d;
      c_0_q    <= c_0_d;
      c_1_q    <= c_1_d;
      c_2_q    <= c_2_d;
      c_3_q    <= c_3_d;
    end
  end

  assign c_0    = c_0_q;
  assign c_1    = c_1_q;
  assign c_2    = c_2_q;
  assign c_3    = c_3_q;
  assign paused = paused_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Directed testbench for stopwatch_time_core.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Each scenario task does its own comparisons against hand-computed segment patterns.
module tb_stopwatch_time_core;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef STOPWATCH_LEADING_BLANK_EN
  localparam logic [6:0] C3_ZERO = 7'b1111111;
`else
  localparam logic [6:0] C3_ZERO = S0;
`endif

  logic       clk_fast = 1'b0;
  logic       rst = 1'b1;
  logic       tick_run = 1'b0;
  logic       tick_adj = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       pause_pulse = 1'b0;
  logic [6:0] c_0, c_1, c_2, c_3;
  logic       paused, wrap;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_fast = ~clk_fast;

  stopwatch_time_core dut (
    .clk_fast   (clk_fast),
    .rst        (rst),
    .tick_run   (tick_run),
    .tick_adj   (tick_adj),
    .adj        (adj),
    .sel        (sel),
    .pause_pulse(pause_pulse),
    .c_0        (c_0),
    .c_1        (c_1),
    .c_2        (c_2),
    .c_3        (c_3),
    .paused     (paused),
    .wrap       (wrap)
  );

  task automatic do_reset();
    rst = 1'b1;
    tick_run = 1'b0; tick_adj = 1'b0; adj = 1'b0; sel = 1'b0; pause_pulse = 1'b0;
    @(negedge clk_fast);
    @(negedge clk_fast);
    rst = 1'b0;
    @(negedge clk_fast);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_fast); tick_run = 1'b1;
      @(negedge clk_fast); tick_run = 1'b0;
    end
  endtask

  task automatic adj_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_fast); tick_adj = 1'b1;
      @(negedge clk_fast); tick_adj = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_fast);
    vectors++;
    if ({c_2, c_1, c_0} !== {S0, S0, S0}) begin
      miscompares++;
      $display("FAIL reset_c210: got %b expected %b", {c_2, c_1, c_0}, {S0, S0, S0});
    end
    vectors++;
    if (c_3 !== C3_ZERO) begin
      miscompares++;
      $display("FAIL reset_c3: got %b expected %b", c_3, C3_ZERO);
    end
    vectors++;
    if ({paused, wrap} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_flags: got paused/wrap %b expected 00", {paused, wrap});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_ticks(7);
    @(negedge clk_fast);
    vectors++;
    if (c_0 !== S7) begin
      miscompares++;
      $display("FAIL mid_pre: got %b expected %b", c_0, S7);
    end
    // Assert reset between edges with a tick pending; outputs must clear at once.
    #2;
    tick_run = 1'b1;
    rst = 1'b1;
    #1;
    vectors++;
    if (c_0 !== S0) begin
      miscompares++;
      $display("FAIL mid_async: got %b expected %b", c_0, S0);
    end
    @(negedge clk_fast);
    tick_run = 1'b0;
    rst = 1'b0;
    @(negedge clk_fast);
    @(negedge clk_fast);
    vectors++;
    if (c_0 !== S0) begin
      miscompares++;
      $display("FAIL mid_after: got %b expected %b", c_0, S0);
    end
  endtask

  task automatic test_run_carry();
    do_reset();
    run_ticks(59);
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {C3_ZERO, S0, S5, S9}) begin
      miscompares++;
      $display("FAIL carry_0059: got %b expected %b", {c_3, c_2, c_1, c_0}, {C3_ZERO, S0, S5, S9});
    end
    run_ticks(1);
    // One edge after the tick only the count has moved; the segments still show 00:59.
    vectors++;
    if (c_0 !== S9) begin
      miscompares++;
      $display("FAIL carry_latency: got %b expected %b", c_0, S9);
    end
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {C3_ZERO, S1, S0, S0}) begin
      miscompares++;
      $display("FAIL carry_0100: got %b expected %b", {c_3, c_2, c_1, c_0}, {C3_ZERO, S1, S0, S0});
    end
  endtask

  task automatic test_full_wrap();
    int wrap_seen;
    wrap_seen = 0;
    do_reset();
    for (int i = 0; i < 3599; i++) begin
      @(negedge clk_fast); tick_run = 1'b1;
      if (wrap) wrap_seen++;
      @(negedge clk_fast); tick_run = 1'b0;
      if (wrap) wrap_seen++;
    end
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {S5, S9, S5, S9}) begin
      miscompares++;
      $display("FAIL wrap_5959: got %b expected %b", {c_3, c_2, c_1, c_0}, {S5, S9, S5, S9});
    end
    vectors++;
    if (wrap_seen !== 0) begin
      miscompares++;
      $display("FAIL wrap_early: got %0d wrap cycles expected 0", wrap_seen);
    end
    run_ticks(1);
    vectors++;
    if (wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pulse: got %b expected 1", wrap);
    end
    @(negedge clk_fast);
    vectors++;
    if (wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_width: got %b expected 0", wrap);
    end
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {C3_ZERO, S0, S0, S0}) begin
      miscompares++;
      $display("FAIL wrap_0000: got %b expected %b", {c_3, c_2, c_1, c_0}, {C3_ZERO, S0, S0, S0});
    end
  endtask

  task automatic test_pause();
    do_reset();
    run_ticks(3);
    // Tick coincident with the pause toggle still counts: 00:03 -> 00:04.
    @(negedge clk_fast); tick_run = 1'b1; pause_pulse = 1'b1;
    @(negedge clk_fast); tick_run = 1'b0; pause_pulse = 1'b0;
    vectors++;
    if (paused !== 1'b1) begin
      miscompares++;
      $display("FAIL pause_set: got %b expected 1", paused);
    end
    run_ticks(5);
    @(negedge clk_fast);
    vectors++;
    if (c_0 !== S4) begin
      miscompares++;
      $display("FAIL pause_hold: got %b expected %b", c_0, S4);
    end
    @(negedge clk_fast); pause_pulse = 1'b1;
    @(negedge clk_fast); pause_pulse = 1'b0;
    vectors++;
    if (paused !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_clear: got %b expected 0", paused);
    end
    run_ticks(1);
    @(negedge clk_fast);
    vectors++;
    if (c_0 !== S5) begin
      miscompares++;
      $display("FAIL pause_resume: got %b expected %b", c_0, S5);
    end
  endtask

  task automatic test_adjust();
    int wrap_seen;
    wrap_seen = 0;
    do_reset();
    adj = 1'b1;
    sel = 1'b0;
    adj_ticks(58);
    sel = 1'b1;
    adj_ticks(30);
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {S5, 7'b0000000, S3, S0}) begin
      miscompares++;
      $display("FAIL adj_5830: got %b expected %b", {c_3, c_2, c_1, c_0}, {S5, 7'b0000000, S3, S0});
    end
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // First step drives both ticks together; later steps interleave a run tick.
      @(negedge clk_fast); tick_adj = 1'b1; tick_run = (i == 0);
      if (wrap) wrap_seen++;
      @(negedge clk_fast); tick_adj = 1'b0; tick_run = 1'b1;
      if (wrap) wrap_seen++;
      @(negedge clk_fast); tick_run = 1'b0;
      if (wrap) wrap_seen++;
    end
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {C3_ZERO, S1, S3, S0}) begin
      miscompares++;
      $display("FAIL adj_0130: got %b expected %b", {c_3, c_2, c_1, c_0}, {C3_ZERO, S1, S3, S0});
    end
    vectors++;
    if (wrap_seen !== 0) begin
      miscompares++;
      $display("FAIL adj_nowrap: got %0d wrap cycles expected 0", wrap_seen);
    end
    // Pause toggles inside adjust; leaving adjust lands in HOLD.
    @(negedge clk_fast); pause_pulse = 1'b1;
    @(negedge clk_fast); pause_pulse = 1'b0; adj = 1'b0;
    vectors++;
    if (paused !== 1'b1) begin
      miscompares++;
      $display("FAIL adj_pause: got %b expected 1", paused);
    end
    run_ticks(2);
    @(negedge clk_fast);
    vectors++;
    if (c_0 !== S0) begin
      miscompares++;
      $display("FAIL adj_hold: got %b expected %b", c_0, S0);
    end
    @(negedge clk_fast); pause_pulse = 1'b1;
    @(negedge clk_fast); pause_pulse = 1'b0;
    run_ticks(1);
    @(negedge clk_fast);
    vectors++;
    if ({c_2, c_1, c_0} !== {S1, S3, S1}) begin
      miscompares++;
      $display("FAIL adj_resume: got %b expected %b", {c_2, c_1, c_0}, {S1, S3, S1});
    end
  endtask

  task automatic test_blanking();
    do_reset();
    run_ticks(599);
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {C3_ZERO, S9, S5, S9}) begin
      miscompares++;
      $display("FAIL blank_0959: got %b expected %b", {c_3, c_2, c_1, c_0}, {C3_ZERO, S9, S5, S9});
    end
    run_ticks(1);
    @(negedge clk_fast);
    vectors++;
    if ({c_3, c_2, c_1, c_0} !== {S1, S0, S0, S0}) begin
      miscompares++;
      $display("FAIL blank_1000: got %b expected %b", {c_3, c_2, c_1, c_0}, {S1, S0, S0, S0});
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_run_carry();
    test_full_wrap();
    test_pause();
    test_adjust();
    test_blanking();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
